// File: rtl/ppm16_pkg.sv
// Shared types and constants for the ppm16 byte packer.
package ppm16_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH_HELD,
        FLUSH_PAD
    } packer_state_t;

    localparam logic [3:0] PAD_NIBBLE = 4'h0;

    // Places the first nibble of a pair high or low depending on bit order.
    function automatic logic [7:0] pack_byte(input logic [3:0] first,
                                             input logic [3:0] second,
                                             input bit         msb_first);
        return msb_first ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/ppm16_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module ppm16_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop);
    assign count   = count_q;

    // Head is forced to zero while empty so the output is defined without resetting storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ppm16_byte_packer.sv
// Packs ppm16_demod nibbles into bytes, marks each packet's last byte and queues them.
// Optional build macro PPM16_PACKER_ODD_PAD_EN emits a trailing odd nibble as a padded byte.
module ppm16_byte_packer
    import ppm16_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              packet_active,
    input  logic                              din_valid,
    input  logic [3:0]                        din,
    input  logic                              dout_ready,
    output logic                              dout_valid,
    output logic [7:0]                        dout,
    output logic                              dout_last,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

`ifdef PPM16_PACKER_ODD_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    packer_state_t state_q, state_d;
    logic       pa_q;
    logic       rise, fall, accept;
    logic [3:0] nib_reg;
    logic       nib_pend;
    logic [7:0] held_reg;
    logic       held_valid;
    logic       rise_pend;
    logic       overflow_q;
    logic       push, push_last, pop;
    logic [7:0] push_byte;
    logic       fifo_full, fifo_empty;
    logic [8:0] fifo_head;

    assign rise   = packet_active & ~pa_q;
    assign fall   = ~packet_active & pa_q;
    assign accept = din_valid & packet_active;
    assign pop    = dout_valid & dout_ready;

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_byte = held_reg;
        push_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise | rise_pend) state_d = RUN;
            end
            RUN: begin
                if (fall) begin
                    state_d = FLUSH_HELD;
                end else if (accept && nib_pend && held_valid) begin
                    push = 1'b1;
                end
            end
            FLUSH_HELD: begin
                push = held_valid;
                if (PAD_EN && nib_pend) begin
                    state_d = FLUSH_PAD;
                end else begin
                    push_last = 1'b1;
                    state_d   = IDLE;
                end
            end
            FLUSH_PAD: begin
                push      = 1'b1;
                push_byte = pack_byte(nib_reg, PAD_NIBBLE, MSB_FIRST);
                push_last = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            pa_q       <= 1'b0;
            nib_reg    <= '0;
            nib_pend   <= 1'b0;
            held_reg   <= '0;
            held_valid <= 1'b0;
            rise_pend  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pa_q    <= packet_active;

            if (state_q == IDLE && (rise || rise_pend)) begin
                nib_pend   <= 1'b0;
                held_valid <= 1'b0;
                overflow_q <= 1'b0;
                rise_pend  <= 1'b0;
            end

            // A new packet starting mid-flush is remembered and started from IDLE.
            if ((state_q == FLUSH_HELD || state_q == FLUSH_PAD) && rise) begin
                rise_pend <= 1'b1;
            end

            if (state_q == RUN && accept) begin
                if (!nib_pend) begin
                    nib_reg  <= din;
                    nib_pend <= 1'b1;
                end else begin
                    held_reg   <= pack_byte(nib_reg, din, MSB_FIRST);
                    held_valid <= 1'b1;
                    nib_pend   <= 1'b0;
                end
            end

            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    ppm16_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data ({push_last, push_byte}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign dout_valid = ~fifo_empty;
    assign dout       = fifo_head[7:0];
    assign dout_last  = fifo_head[8];
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ppm16_byte_packer.sv
// Directed bench for ppm16_byte_packer: an MSB-first instance and an LSB-first instance.
module tb_ppm16_byte_packer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pa = 1'b0;
    logic       dv = 1'b0;
    logic [3:0] din = '0;
    logic       ready = 1'b1;
    logic       sel = 1'b0;

    logic       pa_a, dv_a, pa_b, dv_b;
    logic       dv_a_o, last_a, ovf_a, dv_b_o, last_b, ovf_b;
    logic [7:0] dout_a, dout_b;
    logic [3:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;
    int valid_cyc_a = 0;
    logic [8:0] cap_a[$];
    logic [8:0] cap_b[$];
    logic [8:0] exp_q[$];
    logic [3:0] stim[$];

    assign pa_a = sel ? 1'b0 : pa;
    assign dv_a = sel ? 1'b0 : dv;
    assign pa_b = sel ? pa : 1'b0;
    assign dv_b = sel ? dv : 1'b0;

    always #5 clk = ~clk;

    ppm16_byte_packer #(.FIFO_DEPTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .resetn(resetn), .packet_active(pa_a), .din_valid(dv_a), .din(din),
        .dout_ready(ready), .dout_valid(dv_a_o), .dout(dout_a), .dout_last(last_a),
        .overflow(ovf_a), .fifo_count(cnt_a)
    );

    ppm16_byte_packer #(.FIFO_DEPTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .resetn(resetn), .packet_active(pa_b), .din_valid(dv_b), .din(din),
        .dout_ready(1'b1), .dout_valid(dv_b_o), .dout(dout_b), .dout_last(last_b),
        .overflow(ovf_b), .fifo_count(cnt_b)
    );

    always @(negedge clk) begin
        if (dv_a_o) valid_cyc_a++;
        if (dv_a_o && ready) cap_a.push_back({last_a, dout_a});
        if (dv_b_o) cap_b.push_back({last_b, dout_b});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt();
        pa = 1'b1;
        tick();
        tick();
    endtask

    task automatic send_nibbles();
        foreach (stim[i]) begin
            din = stim[i];
            dv  = 1'b1;
            tick();
            dv  = 1'b0;
            tick();
        end
    endtask

    task automatic end_pkt();
        pa = 1'b0;
        repeat (6) tick();
    endtask

    task automatic run_pkt();
        start_pkt();
        send_nibbles();
        end_pkt();
    endtask

    task automatic compare_cap_a(input string name);
        checks++;
        if (cap_a.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_size: got %0d expected %0d", name, cap_a.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= cap_a.size() || cap_a[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h expected %h", name, i,
                         (i < cap_a.size()) ? cap_a[i] : 9'h1ff, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (dv_a_o !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dv_a_o); end
        checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout_a); end
        checks++; if (last_a !== 1'b0) begin errors++; $display("FAIL reset_dout_last: got %b expected 0", last_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf_a); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", cnt_a); end
        resetn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_msb_first();
        cap_a.delete();
        valid_cyc_a = 0;
        stim = '{4'h1, 4'h2, 4'h3, 4'h4};
        start_pkt();
        send_nibbles();
        pa = 1'b0;
        tick();
        checks++; if (dv_a_o !== 1'b0) begin errors++; $display("FAIL last_latency_early: got valid %b expected 0", dv_a_o); end
        tick();
        checks++;
        if (dv_a_o !== 1'b1 || dout_a !== 8'h34 || last_a !== 1'b1) begin
            errors++;
            $display("FAIL last_latency: got valid %b byte %h last %b expected 1 34 1", dv_a_o, dout_a, last_a);
        end
        repeat (4) tick();
        exp_q = '{9'h012, 9'h134};
        compare_cap_a("msb_first");
        checks++; if (valid_cyc_a != 2) begin errors++; $display("FAIL msb_valid_cycles: got %0d expected 2", valid_cyc_a); end
    endtask

    task automatic test_lsb_first();
        cap_b.delete();
        sel = 1'b1;
        stim = '{4'hA, 4'hB};
        run_pkt();
        sel = 1'b0;
        checks++; if (cap_b.size() != 1) begin errors++; $display("FAIL lsb_size: got %0d expected 1", cap_b.size()); end
        checks++; if (cap_b.size() < 1 || cap_b[0] !== 9'h1BA) begin errors++; $display("FAIL lsb_byte: got %h expected 1ba", (cap_b.size() > 0) ? cap_b[0] : 9'h1ff); end
    endtask

    task automatic test_odd_nibble();
        cap_a.delete();
        stim = '{4'h5, 4'h6, 4'h7};
        run_pkt();
`ifdef PPM16_PACKER_ODD_PAD_EN
        exp_q = '{9'h056, 9'h170};
`else
        exp_q = '{9'h156};
`endif
        compare_cap_a("odd_nibble");
    endtask

    task automatic test_overflow();
        cap_a.delete();
        ready = 1'b0;
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(4'(i));
        run_pkt();
        checks++; if (cnt_a !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", cnt_a); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf_a); end
        checks++;
        if (dv_a_o !== 1'b1 || dout_a !== 8'h01 || last_a !== 1'b0) begin
            errors++;
            $display("FAIL ovf_head_stable: got valid %b byte %h last %b expected 1 01 0", dv_a_o, dout_a, last_a);
        end
        ready = 1'b1;
        repeat (10) tick();
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, 4'(2*k), 4'(2*k+1)});
        compare_cap_a("ovf_drain");
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL ovf_drained_count: got %0d expected 0", cnt_a); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf_a); end
        pa = 1'b1;
        tick();
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_rise: got %b expected 0", ovf_a); end
        end_pkt();
        checks++; if (cap_a.size() != 8) begin errors++; $display("FAIL empty_packet_output: got %0d bytes expected 8", cap_a.size()); end
    endtask

    task automatic test_reset_mid();
        cap_a.delete();
        ready = 1'b0;
        stim = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        start_pkt();
        send_nibbles();
        checks++; if (cnt_a !== 4'd3) begin errors++; $display("FAIL mid_queued_count: got %0d expected 3", cnt_a); end
        resetn = 1'b0;
        #1;
        checks++; if (dv_a_o !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", dv_a_o); end
        checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", cnt_a); end
        pa = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        ready = 1'b1;
        stim = '{4'hC, 4'hD};
        run_pkt();
        exp_q = '{9'h1CD};
        compare_cap_a("after_reset");
    endtask

    task automatic test_quick_restart();
        cap_a.delete();
        stim = '{4'hA, 4'hB};
        start_pkt();
        send_nibbles();
        pa = 1'b0;
        tick();
        pa = 1'b1;
        tick();
        tick();
        stim = '{4'hC, 4'hD};
        send_nibbles();
        end_pkt();
        exp_q = '{9'h1AB, 9'h1CD};
        compare_cap_a("quick_restart");
    endtask

    task automatic test_back_to_back();
        int lasts;
        cap_a.delete();
        stim = '{4'h1, 4'h2, 4'h3};
        run_pkt();
        repeat (16) tick();
        stim = '{4'h8, 4'h9};
        run_pkt();
`ifdef PPM16_PACKER_ODD_PAD_EN
        exp_q = '{9'h012, 9'h130, 9'h189};
`else
        exp_q = '{9'h112, 9'h189};
`endif
        compare_cap_a("back_to_back");
        lasts = 0;
        foreach (cap_a[i]) if (cap_a[i][8]) lasts++;
        checks++; if (lasts != 2) begin errors++; $display("FAIL b2b_last_count: got %0d expected 2", lasts); end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_odd_nibble();
        test_overflow();
        test_reset_mid();
        test_quick_restart();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
